// File: rtl/top_dual_stream_pkg.sv
// Shared types and defaults for the dual-stream source block.
package top_dual_stream_pkg;

  // One stream element: value plus end-of-stream marker.
  typedef struct packed {
    logic [63:0] data;
    logic        eos;
  } stream_elem_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DEF_COUNT = 10;
  localparam logic [63:0] DEF_MULT  = 64'd2;

endpackage

// File: rtl/top_dual_stream_stream_source.sv
// One element stream: emits i*mult for i = 0..COUNT-1, then an EOS token.
// The product is kept as a running sum (acc += mult), which is exactly
// i*mult modulo 2^64 without needing a multiplier.
module stream_source
  import top_dual_stream_pkg::*;
#(
  parameter int COUNT = DEF_COUNT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         clear,
  input  logic [63:0]  mult,
  input  logic         ready,
  output logic         valid,
  output stream_elem_t elem,
  output logic         done
);

  logic [31:0] idx;
  logic [63:0] acc;
  logic [31:0] idx_next;
  logic [63:0] acc_next;
  logic        last;
  logic        fire;

  assign idx_next = idx + 32'd1;
  assign acc_next = acc + mult;
  assign last     = (idx_next == 32'(COUNT));
  assign fire     = valid & ready;

  // Element register: load on start, advance on transfer, retire after EOS.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx   <= '0;
      acc   <= '0;
      valid <= 1'b0;
      elem  <= '0;
      done  <= 1'b0;
    end else if (start) begin
      idx       <= '0;
      acc       <= '0;
      valid     <= 1'b1;
      elem.data <= '0;
      elem.eos  <= (COUNT == 0);
      done      <= 1'b0;
    end else if (fire) begin
      if (elem.eos) begin
        valid <= 1'b0;
        elem  <= '0;
        done  <= 1'b1;
      end else begin
        idx       <= idx_next;
        acc       <= acc_next;
        elem.eos  <= last;
        elem.data <= last ? 64'd0 : acc_next;
      end
    end else if (clear) begin
      idx  <= '0;
      acc  <= '0;
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/top_dual_stream.sv
// Two-stream source: a start token launches two independent element streams
// (stream 0: i, stream 1: i*MULT), each closed by EOS; a completion token
// follows once both EOS tokens are accepted.
// Optional macro DUAL_STREAM_ASSERT_EN enables simulation-only assertions.
module top_dual_stream
  import top_dual_stream_pkg::*;
#(
  parameter int          COUNT = DEF_COUNT,
  parameter logic [63:0] MULT  = DEF_MULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inCtrl_valid,
  output logic        inCtrl_ready,
  output logic        out0_valid,
  input  logic        out0_ready,
  output logic [63:0] out0_data_field0,
  output logic        out0_data_field1,
  output logic        out1_valid,
  input  logic        out1_ready,
  output logic        out2_valid,
  input  logic        out2_ready,
  output logic [63:0] out2_data_field0,
  output logic        out2_data_field1,
  output logic        out3_valid,
  input  logic        out3_ready,
  output logic        outCtrl_valid,
  input  logic        outCtrl_ready
);

  state_t       state, state_nxt;
  logic         start, clear;
  logic         s0_valid, s1_valid, s0_done, s1_done;
  stream_elem_t s0_elem, s1_elem;

  stream_source #(.COUNT(COUNT)) u_s0 (
    .clock (clock),
    .reset (reset),
    .start (start),
    .clear (clear),
    .mult  (64'd1),
    .ready (out0_ready & out3_ready),
    .valid (s0_valid),
    .elem  (s0_elem),
    .done  (s0_done)
  );

  stream_source #(.COUNT(COUNT)) u_s1 (
    .clock (clock),
    .reset (reset),
    .start (start),
    .clear (clear),
    .mult  (MULT),
    .ready (out2_ready & out1_ready),
    .valid (s1_valid),
    .elem  (s1_elem),
    .done  (s1_done)
  );

  // Each data channel and its companion share one registered valid.
  assign out0_valid       = s0_valid;
  assign out3_valid       = s0_valid;
  assign out0_data_field0 = s0_elem.data;
  assign out0_data_field1 = s0_elem.eos;
  assign out2_valid       = s1_valid;
  assign out1_valid       = s1_valid;
  assign out2_data_field0 = s1_elem.data;
  assign out2_data_field1 = s1_elem.eos;

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    inCtrl_ready  = 1'b0;
    outCtrl_valid = 1'b0;
    start         = 1'b0;
    clear         = 1'b0;
    case (state)
      IDLE: begin
        inCtrl_ready = ~reset;
        if (inCtrl_valid && !reset) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (s0_done && s1_done) state_nxt = DONE;
      end
      DONE: begin
        outCtrl_valid = 1'b1;
        if (outCtrl_ready) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DUAL_STREAM_ASSERT_EN
  logic [1:0] eos_cnt0, eos_cnt1;
  logic       eos_fire0, eos_fire1;

  assign eos_fire0 = out0_valid & out0_ready & out3_ready & out0_data_field1;
  assign eos_fire1 = out2_valid & out2_ready & out1_ready & out2_data_field1;

  // Count EOS transfers per stream within one run.
  always_ff @(posedge clock) begin
    if (reset || start) begin
      eos_cnt0 <= '0;
      eos_cnt1 <= '0;
    end else begin
      if (eos_fire0) eos_cnt0 <= eos_cnt0 + 2'd1;
      if (eos_fire1) eos_cnt1 <= eos_cnt1 + 2'd1;
    end
  end

  a_s0_hold: assert property (@(posedge clock) disable iff (reset)
    out0_valid && !(out0_ready && out3_ready) |=>
      out0_valid && $stable(out0_data_field0) && $stable(out0_data_field1));
  a_s1_hold: assert property (@(posedge clock) disable iff (reset)
    out2_valid && !(out2_ready && out1_ready) |=>
      out2_valid && $stable(out2_data_field0) && $stable(out2_data_field1));
  a_comp: assert property (@(posedge clock) disable iff (reset)
    (out3_valid == out0_valid) && (out1_valid == out2_valid));
  a_eos_once0: assert property (@(posedge clock) disable iff (reset)
    eos_fire0 |-> eos_cnt0 == 2'd0);
  a_eos_once1: assert property (@(posedge clock) disable iff (reset)
    eos_fire1 |-> eos_cnt1 == 2'd0);
  a_eos_done: assert property (@(posedge clock) disable iff (reset)
    state == DONE |-> eos_cnt0 == 2'd1 && eos_cnt1 == 2'd1);
  a_ready_idle: assert property (@(posedge clock)
    inCtrl_ready |-> state == IDLE);
`endif

endmodule

// File: tb/tb_top_dual_stream.sv
// Scoreboard bench for top_dual_stream: expected elements are queued when a
// run is started and checked as the DUT transfers them. A second instance
// with COUNT=0 covers the EOS-only case.
module tb_top_dual_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        out0_valid, out1_valid, out2_valid, out3_valid;
  logic        r0, r1, r2, r3, rc;
  logic [63:0] out0_d, out2_d;
  logic        out0_e, out2_e;
  logic        ctrl_valid;

  logic        z_in_valid, z_in_ready;
  logic        z0_valid, z1_valid, z2_valid, z3_valid, z_ctrl_valid;
  logic [63:0] z0_d, z2_d;
  logic        z0_e, z2_e;
  logic        z_rdy = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int ctrl_cnt = 0;
  logic [64:0] q0[$];
  logic [64:0] q1[$];
  logic [64:0] h0_val, h1_val;
  logic        h0_pend = 1'b0, h1_pend = 1'b0;

  always #5 clock = ~clock;

  top_dual_stream #(.COUNT(10), .MULT(64'd2)) dut (
    .clock(clock), .reset(reset),
    .inCtrl_valid(in_valid), .inCtrl_ready(in_ready),
    .out0_valid(out0_valid), .out0_ready(r0),
    .out0_data_field0(out0_d), .out0_data_field1(out0_e),
    .out1_valid(out1_valid), .out1_ready(r1),
    .out2_valid(out2_valid), .out2_ready(r2),
    .out2_data_field0(out2_d), .out2_data_field1(out2_e),
    .out3_valid(out3_valid), .out3_ready(r3),
    .outCtrl_valid(ctrl_valid), .outCtrl_ready(rc)
  );

  top_dual_stream #(.COUNT(0), .MULT(64'd2)) dut0 (
    .clock(clock), .reset(reset),
    .inCtrl_valid(z_in_valid), .inCtrl_ready(z_in_ready),
    .out0_valid(z0_valid), .out0_ready(z_rdy),
    .out0_data_field0(z0_d), .out0_data_field1(z0_e),
    .out1_valid(z1_valid), .out1_ready(z_rdy),
    .out2_valid(z2_valid), .out2_ready(z_rdy),
    .out2_data_field0(z2_d), .out2_data_field1(z2_e),
    .out3_valid(z3_valid), .out3_ready(z_rdy),
    .outCtrl_valid(z_ctrl_valid), .outCtrl_ready(z_rdy)
  );

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Expected contents of one full run; elements are {eos, data}.
  task automatic push_run();
    for (int i = 0; i < 10; i++) begin
      q0.push_back({1'b0, 64'(i)});
      q1.push_back({1'b0, 64'(i) * 64'd2});
    end
    q0.push_back({1'b1, 64'd0});
    q1.push_back({1'b1, 64'd0});
  endtask

  task automatic pulse();
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_ctrl();
    int n0;
    n0 = ctrl_cnt;
    for (int i = 0; i < 300 && ctrl_cnt == n0; i++) @(posedge clock);
    #1;
    chk("ctrl_fire", 65'(ctrl_cnt), 65'(n0 + 1));
  endtask

  // Monitor: score transfers, check stall stability and companion valids.
  always @(negedge clock) begin
    logic f0, f1;
    logic [64:0] e;
    f0 = out0_valid & r0 & r3;
    f1 = out2_valid & r2 & r1;
    if (!reset) begin
      if (h0_pend) chk("s0_hold", {out0_e, out0_d}, h0_val);
      if (h1_pend) chk("s1_hold", {out2_e, out2_d}, h1_val);
      if (out0_valid | out3_valid) chk("s0_comp", 65'(out3_valid), 65'(out0_valid));
      if (out2_valid | out1_valid) chk("s1_comp", 65'(out1_valid), 65'(out2_valid));
      if (f0) begin
        e = (q0.size() > 0) ? q0.pop_front() : '1;
        chk("s0_elem", {out0_e, out0_d}, e);
      end
      if (f1) begin
        e = (q1.size() > 0) ? q1.pop_front() : '1;
        chk("s1_elem", {out2_e, out2_d}, e);
      end
      if (ctrl_valid & rc) begin
        ctrl_cnt++;
        chk("ctrl_order", 65'(q0.size() + q1.size()), 65'd0);
      end
    end
    h0_pend <= !reset && out0_valid && !f0;
    h1_pend <= !reset && out2_valid && !f1;
    h0_val  <= {out0_e, out0_d};
    h1_val  <= {out2_e, out2_d};
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; z_in_valid = 1'b0;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1; r3 = 1'b1; rc = 1'b1;
    cyc(); cyc();
    chk("rst_valids", 65'({out0_valid, out1_valid, out2_valid, out3_valid, ctrl_valid}), 65'd0);
    chk("rst_data0", {out0_e, out0_d}, 65'd0);
    chk("rst_data2", {out2_e, out2_d}, 65'd0);
    chk("rst_inrdy", 65'(in_ready), 65'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_inrdy", 65'(in_ready), 65'd1);

    // Basic run, full throughput, one-cycle start latency.
    push_run();
    pulse();
    chk("lat_v0", 65'(out0_valid), 65'd1);
    chk("lat_v2", 65'(out2_valid), 65'd1);
    chk("run_inrdy", 65'(in_ready), 65'd0);
    wait_ctrl();
    chk("post_valid", 65'(out0_valid | out2_valid | ctrl_valid), 65'd0);
    @(negedge clock);
    chk("back_idle", 65'(in_ready), 65'd1);

    // Start held high for 3 cycles: a single run only.
    push_run();
    in_valid = 1'b1;
    cyc(); cyc(); cyc();
    in_valid = 1'b0;
    wait_ctrl();
    repeat (3) cyc();
    chk("no_rerun", 65'(out0_valid | out2_valid), 65'd0);

    // Stream 1 stalled; stream 0 finishes; completion waits for stream 1.
    push_run();
    rc = 1'b0;
    pulse();
    repeat (3) cyc();
    r2 = 1'b0;
    repeat (14) cyc();
    chk("s0_indep", 65'(q0.size()), 65'd0);
    chk("s1_stall_q", 65'(q1.size()), 65'd8);
    chk("s1_stall_v", 65'(out2_valid), 65'd1);
    chk("ctrl_wait", 65'(ctrl_valid), 65'd0);
    r2 = 1'b1;
    for (int i = 0; i < 50 && !ctrl_valid; i++) cyc();
    chk("ctrl_up", 65'(ctrl_valid), 65'd1);
    repeat (3) cyc();
    chk("ctrl_hold", 65'(ctrl_valid), 65'd1);
    rc = 1'b1;
    wait_ctrl();

    // Companion not ready: stream 0 must not advance.
    push_run();
    pulse();
    repeat (2) cyc();
    r3 = 1'b0;
    repeat (4) cyc();
    chk("s0_noadv", 65'(q0.size()), 65'd9);
    chk("s0_held", {out0_e, out0_d}, 65'd2);
    r3 = 1'b1;
    wait_ctrl();

    // Reset mid-run, then a fresh run from element 0.
    @(negedge clock);
    push_run();
    pulse();
    repeat (4) cyc();
    reset = 1'b1;
    cyc();
    chk("mrst_valids", 65'({out0_valid, out1_valid, out2_valid, out3_valid, ctrl_valid}), 65'd0);
    chk("mrst_data", {out0_e, out0_d, out2_e, out2_d} == 130'd0 ? 65'd0 : 65'd1, 65'd0);
    chk("mrst_inrdy", 65'(in_ready), 65'd0);
    q0.delete(); q1.delete();
    reset = 1'b0;
    push_run();
    pulse();
    chk("restart0", {out0_e, out0_d}, 65'd0);
    wait_ctrl();

    // COUNT=0 instance: EOS only on both streams, then completion.
    z_in_valid = 1'b1;
    cyc();
    z_in_valid = 1'b0;
    chk("z_v", 65'({z0_valid, z1_valid, z2_valid, z3_valid}), 65'hf);
    chk("z_s0", {z0_e, z0_d}, {1'b1, 64'd0});
    chk("z_s1", {z2_e, z2_d}, {1'b1, 64'd0});
    cyc();
    chk("z_after", 65'({z0_valid, z2_valid}), 65'd0);
    for (int i = 0; i < 10 && !z_ctrl_valid; i++) cyc();
    chk("z_ctrl", 65'(z_ctrl_valid), 65'd1);
    cyc();
    chk("z_idle", 65'(z_in_ready), 65'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
